// File: rtl/data_ram_responder_pkg.sv
// Shared CPU/RAM definitions: port widths, access-type encoding, responder FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cpu_pkg;

  localparam int CPU_ADDR_W = 8;
  localparam int CPU_DATA_W = 4;

  // ram_RW encoding as driven by the CPU
  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  // Responder FSM: zeroing the array after reset, or serving CPU accesses
  typedef enum logic [0:0] {
    RAM_CLEAR = 1'b0,
    RAM_IDLE  = 1'b1
  } ram_state_t;

endpackage

// File: rtl/data_ram_responder_ram_array.sv
// Single-port synchronous storage: one write port, one registered read port on a shared address.
// Latency: write lands on the edge; read data registered one cycle after the read enable.
// Backpressure: none; accepts one access per cycle.
module ram_array #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  // Storage has no reset so it maps onto plain RAM macros / LUT RAM
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  // Write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  // Registered read port; holds its value whenever no read is issued
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/data_ram_responder.sv
// Memory-side responder for the CPU RAM port, zeroing the whole array after every reset.
// Latency: writes take effect on the sampling edge; read data is valid one cycle after the strobe.
// Backpressure: none; accesses during the clear are dropped and flagged on the sticky ram_err.
module data_ram_responder
  import cpu_pkg::*;
#(
  parameter int ADDR_W         = CPU_ADDR_W,
  parameter int DATA_W         = CPU_DATA_W,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ram_RW,
  input  logic              ram_EN,
  input  logic [ADDR_W-1:0] ram_address_bus,
  input  logic [DATA_W-1:0] ram_data_bus_out,
  output logic [DATA_W-1:0] ram_data_bus_in,
  output logic              ram_busy,
  output logic              ram_err
);

  localparam logic [ADDR_W-1:0] CLR_LAST = '1;

  ram_state_t        state;
  logic [ADDR_W-1:0] clr_cnt;
  logic              clearing;
  logic              arr_we;
  logic              arr_re;
  logic [ADDR_W-1:0] arr_addr;
  logic [DATA_W-1:0] arr_wdata;

  assign clearing = (state == RAM_CLEAR);
  assign ram_busy = clearing;

  // Steer the single array port between the clear sweep and the CPU
  always_comb begin
    arr_we    = 1'b0;
    arr_re    = 1'b0;
    arr_addr  = ram_address_bus;
    arr_wdata = ram_data_bus_out;
    if (clearing) begin
      arr_we    = 1'b1;
      arr_addr  = clr_cnt;
      arr_wdata = '0;
    end else if (ram_EN) begin
      arr_we = (ram_RW == RW_WRITE);
      arr_re = (ram_RW == RW_READ);
    end
  end

  // Clear sweep: one address per edge, leave CLEAR on the edge that zeroes the last word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= CLEAR_ON_RESET ? RAM_CLEAR : RAM_IDLE;
      clr_cnt <= '0;
    end else if (clearing) begin
      clr_cnt <= clr_cnt + 1'b1;
      if (clr_cnt == CLR_LAST) begin
        state <= RAM_IDLE;
      end
    end
  end

  // Sticky error: any strobe while the sweep is running
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_err <= 1'b0;
    end else if (clearing && ram_EN) begin
      ram_err <= 1'b1;
    end
  end

  ram_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram_array (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (arr_we),
    .re    (arr_re),
    .addr  (arr_addr),
    .wdata (arr_wdata),
    .rdata (ram_data_bus_in)
  );

endmodule

// File: tb/tb_data_ram_responder.sv
module tb_data_ram_responder;

  logic       clk;
  logic       rst_n;
  logic       ram_RW;
  logic       ram_EN;
  logic [7:0] ram_address_bus;
  logic [3:0] ram_data_bus_out;
  logic [3:0] ram_data_bus_in;
  logic       ram_busy;
  logic       ram_err;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference memory and expected read-data register
  logic [3:0] model [256];
  logic [3:0] exp_rd;

  data_ram_responder dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .ram_RW           (ram_RW),
    .ram_EN           (ram_EN),
    .ram_address_bus  (ram_address_bus),
    .ram_data_bus_out (ram_data_bus_out),
    .ram_data_bus_in  (ram_data_bus_in),
    .ram_busy         (ram_busy),
    .ram_err          (ram_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic rw, input logic [7:0] a, input logic [3:0] d);
    ram_EN           = en;
    ram_RW           = rw;
    ram_address_bus  = a;
    ram_data_bus_out = d;
  endtask

  // One IDLE-phase access: drive, take the edge, then update the reference
  task automatic access(input logic en, input logic rw, input logic [7:0] a, input logic [3:0] d);
    drive(en, rw, a, d);
    tick();
    if (en && !rw) model[a] = d;
    if (en && rw)  exp_rd = model[a];
    drive(1'b0, 1'b0, 8'h00, 4'h0);
  endtask

  task automatic model_zero();
    for (int i = 0; i < 256; i++) model[i] = 4'h0;
    exp_rd = 4'h0;
  endtask

  // Count edges until busy drops, bounded so a stuck DUT still reaches the summary
  task automatic wait_clear(output int n);
    n = 0;
    while (ram_busy && n < 400) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int n;
    logic [7:0] a;
    logic [3:0] d;
    logic       rw;

    rst_n = 1'b0;
    drive(1'b0, 1'b0, 8'h00, 4'h0);
    #12;
    chk("rst_data", ram_data_bus_in, 4'h0);
    chk("rst_err",  ram_err, 1'b0);
    chk("rst_busy", ram_busy, 1'b1);

    // Release between edges: the next rising edge is clear edge 1
    tick();
    rst_n = 1'b1;
    wait_clear(n);
    chk("clear_len", n, 256);
    chk("busy_low", ram_busy, 1'b0);
    chk("err_after_clear", ram_err, 1'b0);
    model_zero();

    access(1'b1, 1'b1, 8'h00, 4'h0); chk("rd_00", ram_data_bus_in, 4'h0);
    access(1'b1, 1'b1, 8'h7F, 4'h0); chk("rd_7f", ram_data_bus_in, 4'h0);
    access(1'b1, 1'b1, 8'hFF, 4'h0); chk("rd_ff", ram_data_bus_in, 4'h0);

    access(1'b1, 1'b0, 8'h3C, 4'hA);
    chk("wr_no_rd_change", ram_data_bus_in, 4'h0);
    access(1'b1, 1'b1, 8'h3C, 4'h0);
    chk("rd_3c", ram_data_bus_in, 4'hA);

    access(1'b1, 1'b0, 8'h00, 4'h1);
    access(1'b1, 1'b0, 8'hFF, 4'hF);
    for (int i = 0; i < 4; i++) begin
      access(1'b1, 1'b1, (i % 2) ? 8'hFF : 8'h00, 4'h0);
      chk("alt_rd", ram_data_bus_in, (i % 2) ? 4'hF : 4'h1);
    end
    access(1'b0, 1'b1, 8'h00, 4'h0); chk("hold_en0_a", ram_data_bus_in, 4'hF);
    access(1'b0, 1'b0, 8'h00, 4'h5); chk("hold_en0_b", ram_data_bus_in, 4'hF);
    access(1'b1, 1'b0, 8'h10, 4'h5); chk("hold_on_wr", ram_data_bus_in, 4'hF);
    access(1'b1, 1'b1, 8'h00, 4'h0); chk("en0_no_write", ram_data_bus_in, 4'h1);

    // Random access stream against the reference array
    for (int i = 0; i < 1000; i++) begin
      a  = 8'($urandom_range(0, 255));
      d  = 4'($urandom_range(0, 15));
      rw = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) access(1'b0, rw, a, d);
      else access(1'b1, rw, a, d);
      chk("rnd_rd", ram_data_bus_in, exp_rd);
    end
    chk("rnd_err", ram_err, 1'b0);

    // Reset while IDLE: outputs return to reset values without waiting for an edge
    access(1'b1, 1'b0, 8'h80, 4'h9);
    access(1'b1, 1'b1, 8'h80, 4'h0);
    chk("rd_80", ram_data_bus_in, 4'h9);
    #2 rst_n = 1'b0;
    #1;
    chk("idle_rst_data", ram_data_bus_in, 4'h0);
    chk("idle_rst_busy", ram_busy, 1'b1);

    // Access attempted on clear edge 10
    tick();
    rst_n = 1'b1;
    repeat (9) tick();
    chk("err_before", ram_err, 1'b0);
    drive(1'b1, 1'b1, 8'h80, 4'h0);
    tick();
    drive(1'b0, 1'b0, 8'h00, 4'h0);
    chk("err_set", ram_err, 1'b1);
    chk("err_data_held", ram_data_bus_in, 4'h0);
    wait_clear(n);
    chk("clear_rest", n, 246);
    chk("err_sticky_idle", ram_err, 1'b1);
    model_zero();
    access(1'b1, 1'b1, 8'h80, 4'h0); chk("cleared_80", ram_data_bus_in, 4'h0);
    access(1'b1, 1'b0, 8'h80, 4'h6);
    access(1'b1, 1'b1, 8'h80, 4'h0); chk("wr_after_err", ram_data_bus_in, 4'h6);
    chk("err_sticky_acc", ram_err, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("err_cleared", ram_err, 1'b0);

    // Reset pulse at clear edge 100 restarts a full sweep
    tick();
    rst_n = 1'b1;
    repeat (100) tick();
    chk("busy_mid", ram_busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("busy_in_pulse", ram_busy, 1'b1);
    #2 rst_n = 1'b1;
    wait_clear(n);
    chk("clear_restart", n, 256);
    model_zero();
    access(1'b1, 1'b1, 8'h80, 4'h0); chk("recleared_80", ram_data_bus_in, 4'h0);
    for (int i = 0; i < 8; i++) begin
      a = 8'($urandom_range(0, 255));
      access(1'b1, 1'b1, a, 4'h0);
      chk("recleared_rnd", ram_data_bus_in, 4'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
